// File: rtl/mux_rr_n.sv
// mux_rr_n: N-channel registered mux, manual or round-robin select, valid/ready on both sides.
// Define MUX_PARITY_EN to add out_parity (even parity of out_data, registered alongside it).
module mux_rr_n #(
    parameter int WIDTH = 8,
    parameter int N = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef MUX_PARITY_EN
    output logic [SELW-1:0]    out_chan,
    output logic               out_parity
`else
    output logic [SELW-1:0]    out_chan
`endif
);
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [SELW-1:0]   r_out_chan;
    logic [SELW-1:0]   r_ptr;
    logic              w_valid_nxt;
    logic              w_rr_hit;
    logic [SELW-1:0]   w_rr_chan;
    logic [SELW-1:0]   w_scan;
    logic              w_has;
    logic [SELW-1:0]   w_cand;
    logic              w_can_load;
    logic              w_grant;
    logic              w_xfer;
    logic [WIDTH-1:0]  w_cand_data;
    logic [SELW-1:0]   w_ptr_nxt;

    // Scan downward so the last hit written is the first valid channel at or after r_ptr.
    always_comb begin
        w_rr_hit  = 1'b0;
        w_rr_chan = '0;
        w_scan    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_scan = (int'(r_ptr) + k >= N) ? SELW'(int'(r_ptr) + k - N) : SELW'(int'(r_ptr) + k);
            if (in_valid[w_scan]) begin
                w_rr_hit  = 1'b1;
                w_rr_chan = w_scan;
            end
        end
    end

    assign w_has       = mode ? w_rr_hit : (int'(sel) < N);
    assign w_cand      = mode ? w_rr_chan : sel;
    assign w_can_load  = ~r_out_valid | out_ready;
    assign w_grant     = w_can_load & w_has & ~rst;
    assign w_xfer      = w_grant & in_valid[w_cand];
    assign w_cand_data = in_data[w_cand*WIDTH +: WIDTH];
    assign w_ptr_nxt   = (int'(w_cand) == N - 1) ? '0 : w_cand + 1'b1;

    // EMPTY/FULL is carried by r_out_valid; a drain with a simultaneous load stays FULL.
    always_ff @(posedge clk) begin
        if (rst) r_out_valid <= 1'b0;
        else     r_out_valid <= w_valid_nxt;
    end

    always_comb begin
        w_valid_nxt = w_xfer | (r_out_valid & ~out_ready);
    end

    always_comb begin
        in_ready = w_grant ? (N'(1) << w_cand) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data <= '0;
            r_out_chan <= '0;
            r_ptr      <= '0;
        end else begin
            if (w_xfer) begin
                r_out_data <= w_cand_data;
                r_out_chan <= w_cand;
            end
            if (w_xfer & mode) r_ptr <= w_ptr_nxt;
        end
    end

`ifdef MUX_PARITY_EN
    logic r_out_parity;
    always_ff @(posedge clk) begin
        if (rst)         r_out_parity <= 1'b0;
        else if (w_xfer) r_out_parity <= ^w_cand_data;
    end
    assign out_parity = r_out_parity;
`endif

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
endmodule

// File: tb/tb_mux_rr_n.sv
// tb_mux_rr_n: directed stimulus on a 4-channel and a 3-channel mux, checked against a
// transaction-level model plus hand-computed expectations.
module tb_mux_rr_n;
    logic        clk = 0;
    logic        rst, mode, out_ready, out_valid;
    logic [1:0]  sel, out_chan;
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_ready;
    logic [7:0]  out_data;
    logic        mode3, out_ready3, out_valid3;
    logic [1:0]  sel3, out_chan3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic [7:0]  out_data3;
`ifdef MUX_PARITY_EN
    logic        out_parity, out_parity3;
`endif
    int          checks = 0, errors = 0;
    bit          mon_en = 0;
    logic        m_valid, m_par;
    logic [7:0]  m_data;
    logic [1:0]  m_chan, m_ptr;

    always #5 clk = ~clk;

    mux_rr_n #(.WIDTH(8), .N(4)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef MUX_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_chan(out_chan));

    mux_rr_n #(.WIDTH(8), .N(3)) dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_data(in_data3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3),
`ifdef MUX_PARITY_EN
        .out_parity(out_parity3),
`endif
        .out_chan(out_chan3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {found, channel}: manual picks sel, round-robin picks first valid at ptr, ptr+1, ... mod 4
    function automatic logic [2:0] pick(input logic md, input logic [1:0] s,
                                        input logic [3:0] v, input logic [1:0] p);
        if (!md) return {1'b1, s};
        for (int k = 0; k < 4; k++) begin
            int c = (int'(p) + k) % 4;
            if (v[2'(c)]) return {1'b1, 2'(c)};
        end
        return 3'b000;
    endfunction

    function automatic logic [3:0] model_ready();
        logic [2:0] pk = pick(mode, sel, in_valid, m_ptr);
        if (rst || (m_valid && !out_ready) || !pk[2]) return 4'b0000;
        return 4'b0001 << pk[1:0];
    endfunction

    function automatic logic [1:0] model_chan();
        logic [2:0] pk = pick(mode, sel, in_valid, m_ptr);
        return pk[1:0];
    endfunction

    function automatic logic model_xfer();
        logic [3:0] r = model_ready();
        return r[model_chan()] && in_valid[model_chan()];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 0; m_data <= 0; m_chan <= 0; m_ptr <= 0; m_par <= 0;
        end else if (model_xfer()) begin
            m_valid <= 1;
            m_data  <= in_data[model_chan()*8 +: 8];
            m_par   <= ^in_data[model_chan()*8 +: 8];
            m_chan  <= model_chan();
            if (mode) m_ptr <= model_chan() + 2'd1;
        end else if (out_ready) begin
            m_valid <= 0;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready", 32'(in_ready), 32'(model_ready()));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_chan", 32'(out_chan), 32'(m_chan));
`ifdef MUX_PARITY_EN
            chk("out_parity", 32'(out_parity), 32'(m_par));
`endif
        end
    end

    initial begin
        logic [1:0] seq4 [3] = '{2'd1, 2'd3, 2'd1};
        // {mode, sel[1:0], in_valid[3:0], out_ready}
        logic [7:0] vec [12] = '{8'b1_00_0110_1, 8'b1_00_0110_0, 8'b0_11_0000_1, 8'b0_11_1000_1,
                                 8'b1_00_0001_1, 8'b1_00_1111_1, 8'b1_00_1111_0, 8'b1_00_1111_1,
                                 8'b0_01_0010_0, 8'b0_01_0010_1, 8'b1_00_0000_1, 8'b1_00_0000_1};
        rst = 1; mode = 0; sel = 0; in_valid = 4'hF; in_data = 32'h44332211; out_ready = 1;
        mode3 = 0; sel3 = 0; in_valid3 = 0; in_data3 = 0; out_ready3 = 1;
        // reset with all channels valid
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst out_data", 32'(out_data), 0);
        chk("rst out_chan", 32'(out_chan), 0);
        chk("rst in_ready", 32'(in_ready), 0);
        mon_en = 1;
        // manual select of channel 2
        @(posedge clk); #1;
        rst = 0; mode = 0; sel = 2; in_valid = 4'b0100; in_data = 32'h44A52211;
        @(negedge clk);
        chk("man in_ready", 32'(in_ready), 32'b0100);
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        chk("man out_data", 32'(out_data), 32'hA5);
        chk("man out_chan", 32'(out_chan), 2);
        chk("man out_valid", 32'(out_valid), 1);
        // round-robin over all channels, no bubbles
        @(posedge clk); #1;
        mode = 1; in_valid = 4'hF; in_data = 32'h33221100;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("rr4 out_chan", 32'(out_chan), 32'(i % 4));
            chk("rr4 out_valid", 32'(out_valid), 1);
        end
        // sparse round-robin, then backpressure
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; mode = 1; in_valid = 4'b1010; in_data = 32'hD3C2B1A0; out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 2) out_ready = 0;
            @(negedge clk);
            chk("rr2 out_chan", 32'(out_chan), 32'(seq4[i]));
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold in_ready", 32'(in_ready), 0);
            chk("hold out_data", 32'(out_data), 32'hB1);
            chk("hold out_valid", 32'(out_valid), 1);
        end
        @(posedge clk); #1;
        out_ready = 1;
        @(negedge clk);
        chk("release in_ready", 32'(in_ready), 32'b1000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("release out_chan", 32'(out_chan), 3);
        chk("release out_data", 32'(out_data), 32'hD3);
        // N=3 with out-of-range manual select
        @(posedge clk); #1;
        in_valid = 0; sel3 = 1; in_valid3 = 3'b010; in_data3 = 24'h5A3C1E; out_ready3 = 1;
        @(posedge clk); #1;
        sel3 = 3; in_valid3 = 3'b111; out_ready3 = 0;
        @(negedge clk);
        chk("n3 in_ready", 32'(in_ready3), 0);
        chk("n3 out_data", 32'(out_data3), 32'h3C);
        chk("n3 out_valid held", 32'(out_valid3), 1);
        @(posedge clk); #1;
        out_ready3 = 1;
        @(negedge clk);
        chk("n3 in_ready drain", 32'(in_ready3), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("n3 out_valid drop", 32'(out_valid3), 0);
`ifdef MUX_PARITY_EN
        @(posedge clk); #1;
        mode = 0; sel = 0; in_valid = 4'b0001; in_data = 32'h00000007; out_ready = 1;
        @(posedge clk); #1;
        in_data = 32'h00000003;
        @(negedge clk);
        chk("parity 07", 32'(out_parity), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("parity 03", 32'(out_parity), 0);
`endif
        // mixed vectors: mode switches keep ptr, manual sel without valid, stalls
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            mode = vec[i][7]; sel = vec[i][6:5]; in_valid = vec[i][4:1]; out_ready = vec[i][0];
            in_data = 32'h1F2E3D4C ^ (i * 32'h01010101);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
